mst_pref_mc: RTL and testbench

// Multi-channel prefetch buffer between NCH streaming data generators and the master flow-control

---
 rtl/mst_pref_pkg.sv | 35 +++
 rtl/mst_pref_mc_if.sv | 27 ++
 rtl/mst_pref_chfifo.sv | 113 +++++++++++
 rtl/mst_pref_mc.sv | 104 ++++++++++
 tb/tb_mst_pref_mc.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mst_pref_pkg.sv
`default_nettype none
// mst_pref_pkg: shared defaults, channel state encoding and output word layout for mst_pref_mc.
// Rev 1.0
package mst_pref_pkg;

  localparam int NCH_DEF     = 2;
  localparam int DW_DEF      = 16;
  localparam int DEPTH_DEF   = 4;
  localparam int GEN_LAT_DEF = 1;
  localparam int ADDRBIT_DEF = $clog2(DEPTH_DEF);
  localparam int CHW_DEF     = $clog2(NCH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } ch_state_e;

  // Output word is {valid, chid, data} with data in the low bits.
  localparam int DOUT_DATA_LSB = 0;

  function automatic int dout_chid_lsb(input int dw);
    return dw;
  endfunction

  function automatic int dout_vld_bit(input int dw, input int chw);
    return dw + chw;
  endfunction

  function automatic int dout_w(input int dw, input int chw);
    return 1 + chw + dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mst_pref_mc_if.sv
`default_nettype none
// mst_pref_mc_if: reader and generator signals of the prefetch buffer; slave = buffer side.
// Rev 1.0
interface mst_pref_mc_if #(
  parameter int NCH = mst_pref_pkg::NCH_DEF,
  parameter int DW  = mst_pref_pkg::DW_DEF,
  parameter int CHW = mst_pref_pkg::CHW_DEF
);
  logic [NCH-1:0]                            prefena;
  logic [NCH-1:0]                            prefflush;
  logic                                      prefreq;
  logic                                      prefvld;
  logic [mst_pref_pkg::dout_w(DW, CHW)-1:0]  prefdout;
  logic [NCH-1:0]                            genreq;
  logic [NCH*DW-1:0]                         gendat;

  modport master (
    output prefena, prefflush, prefreq, gendat,
    input  prefvld, prefdout, genreq
  );

  modport slave (
    input  prefena, prefflush, prefreq, gendat,
    output prefvld, prefdout, genreq
  );
endinterface
`default_nettype wire

// File: rtl/mst_pref_chfifo.sv
`default_nettype none
// mst_pref_chfifo: one channel - IDLE/RUN/FLUSH control, request credit, return tracking, FIFO.
// Rev 1.0
module mst_pref_chfifo
  import mst_pref_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDRBIT = ADDRBIT_DEF,
  parameter int GEN_LAT = GEN_LAT_DEF
) (
  input  wire            clk,
  input  wire            rst,
  input  wire            ena_i,
  input  wire            flush_i,
  input  wire            pop_i,
  input  wire [DW-1:0]   gendat_i,
  output logic           genreq_o,
  output logic           nempty_o,
  output logic [DW-1:0]  head_o
);

  localparam logic [ADDRBIT:0]   c_OCC_ONE  = (ADDRBIT+1)'(1);
  localparam logic [ADDRBIT:0]   c_OCC_FULL = (ADDRBIT+1)'(DEPTH);
  localparam logic [ADDRBIT+1:0] c_CREDIT   = (ADDRBIT+2)'(DEPTH);
  localparam logic [ADDRBIT-1:0] c_PTR_ONE  = ADDRBIT'(1);

  ch_state_e          state_q;
  logic [ADDRBIT:0]   occ_q, occ_d;
  logic [ADDRBIT:0]   infl_q, infl_d;
  logic [ADDRBIT-1:0] wptr_q, rptr_q;
  logic [GEN_LAT-1:0] req_sr_q, req_sr_d;
  logic [DW-1:0]      mem_q [DEPTH];
  logic [ADDRBIT+1:0] credit_used;
  logic               ret, wr, rd;

  assign credit_used = {1'b0, occ_q} + {1'b0, infl_q};
  assign genreq_o    = (state_q == ST_RUN) && (credit_used < c_CREDIT);
  assign nempty_o    = (occ_q != '0);
  assign head_o      = mem_q[rptr_q];

  // A return coinciding with the flush edge belongs to the flushed stream.
  assign ret = req_sr_q[GEN_LAT-1];
  assign wr  = ret && !flush_i && (state_q != ST_FLUSH);
  assign rd  = pop_i && !flush_i && nempty_o;

  always_comb begin
    req_sr_d = req_sr_q;
    for (int i = GEN_LAT-1; i > 0; i--) req_sr_d[i] = req_sr_q[i-1];
    req_sr_d[0] = genreq_o;
  end

  always_comb begin
    occ_d = occ_q;
    if (flush_i)         occ_d = '0;
    else if (wr && !rd)  occ_d = occ_q + c_OCC_ONE;
    else if (!wr && rd)  occ_d = occ_q - c_OCC_ONE;
  end

  always_comb begin
    infl_d = infl_q;
    if (genreq_o && !ret)      infl_d = infl_q + c_OCC_ONE;
    else if (!genreq_o && ret) infl_d = infl_q - c_OCC_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (flush_i) begin
      state_q <= ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:  if (ena_i)  state_q <= ST_RUN;
        ST_RUN:   if (!ena_i) state_q <= ST_IDLE;
        ST_FLUSH: if (infl_q == '0) state_q <= ena_i ? ST_RUN : ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q    <= '0;
      infl_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      req_sr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      req_sr_q <= req_sr_d;
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr) wptr_q <= wptr_q + c_PTR_ONE;
        if (rd) rptr_q <= rptr_q + c_PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= gendat_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr && !rd && occ_q == c_OCC_FULL));

  a_no_stray_return: assert property (@(posedge clk) disable iff (rst)
    !(ret && infl_q == '0));

endmodule
`default_nettype wire

// File: rtl/mst_pref_mc.sv
`default_nettype none
// mst_pref_mc: multi-channel prefetch buffer with round-robin show-ahead read port.
// Rev 1.0 - optional underrun counter under `MST_PREF_STAT_EN.
module mst_pref_mc
  import mst_pref_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDRBIT = $clog2(DEPTH),
  parameter int GEN_LAT = GEN_LAT_DEF,
  parameter int CHW     = $clog2(NCH)
) (
  input  wire           clk,
  input  wire           rst,
  mst_pref_mc_if.slave  pref_if
`ifdef MST_PREF_STAT_EN
  ,
  output logic [15:0]   pref_undrn_o
`endif
);

  logic [NCH-1:0] nempty;
  logic [NCH-1:0] ch_pop;
  logic [NCH-1:0] genreq_w;
  logic [DW-1:0]  head [NCH];
  logic [CHW-1:0] ptr_q, ptr_d, grant;
  logic           any_vld, pop;

  function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NCH) s = s - NCH;
    return CHW'(s);
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign ch_pop[c] = pop && (grant == CHW'(c));

    mst_pref_chfifo #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .ADDRBIT (ADDRBIT),
      .GEN_LAT (GEN_LAT)
    ) u_chfifo (
      .clk      (clk),
      .rst      (rst),
      .ena_i    (pref_if.prefena[c]),
      .flush_i  (pref_if.prefflush[c]),
      .pop_i    (ch_pop[c]),
      .gendat_i (pref_if.gendat[c*DW +: DW]),
      .genreq_o (genreq_w[c]),
      .nempty_o (nempty[c]),
      .head_o   (head[c])
    );
  end

  assign pref_if.genreq = genreq_w;

  // First non-empty channel at or after ptr, ascending with wrap.
  always_comb begin
    any_vld = 1'b0;
    grant   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!any_vld && nempty[wrap_add(ptr_q, k)]) begin
        any_vld = 1'b1;
        grant   = wrap_add(ptr_q, k);
      end
    end
  end

  assign pop             = pref_if.prefreq && any_vld;
  assign pref_if.prefvld = any_vld;

  always_comb begin
    pref_if.prefdout = '0;
    if (any_vld) pref_if.prefdout = {1'b1, grant, head[grant]};
  end

  always_comb begin
    ptr_d = ptr_q;
    if (pop) ptr_d = wrap_add(grant, 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

`ifdef MST_PREF_STAT_EN
  logic [15:0] undrn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      undrn_q <= '0;
    else if (pref_if.prefreq && !any_vld && undrn_q != 16'hFFFF)
      undrn_q <= undrn_q + 16'd1;
  end

  assign pref_undrn_o = undrn_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mst_pref_mc.sv
`default_nettype none
// tb_mst_pref_mc: directed scenarios plus random traffic against a queue-based channel model.
// Rev 1.0
module tb_mst_pref_mc;
  import mst_pref_pkg::*;

  localparam int NCH     = 2;
  localparam int DW      = 16;
  localparam int DEPTH   = 4;
  localparam int GEN_LAT = 1;
  localparam int CHW     = 1;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  logic clk;
  logic rst;
  logic [15:0] pref_undrn;

  mst_pref_mc_if #(.NCH(NCH), .DW(DW), .CHW(CHW)) bus ();

  mst_pref_mc #(
    .NCH(NCH), .DW(DW), .DEPTH(DEPTH), .GEN_LAT(GEN_LAT), .CHW(CHW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pref_if      (bus)
`ifdef MST_PREF_STAT_EN
    ,
    .pref_undrn_o (pref_undrn)
`endif
  );

`ifndef MST_PREF_STAT_EN
  assign pref_undrn = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Model: per-channel word queues and queues of return cycle numbers.
  logic [DW-1:0] q  [NCH][$];
  int            rt [NCH][$];
  int            mode [NCH];
  int            ptr;
  int            undrn;

  logic [NCH-1:0] d_ena, d_flush;
  logic           d_req;
  logic [DW-1:0]  gd [NCH];

  logic [NCH-1:0] eg;
  logic           ev;
  int             gid;
  logic [17:0]    edout;

  logic [NCH-1:0] s_genreq;
  logic           s_vld;
  logic [17:0]    s_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      q[c].delete();
      rt[c].delete();
      mode[c] = M_IDLE;
    end
    ptr   = 0;
    undrn = 0;
  endtask

  task automatic model_expect();
    ev  = 1'b0;
    gid = 0;
    for (int c = 0; c < NCH; c++)
      eg[c] = (mode[c] == M_RUN) && (q[c].size() + rt[c].size() < DEPTH);
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (ptr + k) % NCH;
      if (!ev && q[idx].size() != 0) begin
        ev  = 1'b1;
        gid = idx;
      end
    end
    edout = ev ? {1'b1, 1'(gid), q[gid][0]} : 18'd0;
  endtask

  task automatic model_advance();
    logic popped;
    popped = d_req && ev;
    for (int c = 0; c < NCH; c++) begin
      int  inf_now;
      logic ret;
      inf_now = rt[c].size();
      ret     = (inf_now > 0) && (rt[c][0] == cyc);
      if (ret) void'(rt[c].pop_front());
      if (d_flush[c]) begin
        q[c].delete();
      end else begin
        if (popped && gid == c) void'(q[c].pop_front());
        if (ret && mode[c] != M_FLUSH) q[c].push_back(gd[c]);
      end
      if (eg[c]) rt[c].push_back(cyc + GEN_LAT);
      if (d_flush[c])                           mode[c] = M_FLUSH;
      else if (mode[c] == M_IDLE && d_ena[c])   mode[c] = M_RUN;
      else if (mode[c] == M_RUN && !d_ena[c])   mode[c] = M_IDLE;
      else if (mode[c] == M_FLUSH && inf_now == 0) mode[c] = d_ena[c] ? M_RUN : M_IDLE;
    end
    if (popped) ptr = (gid + 1) % NCH;
    if (d_req && !ev && undrn < 16'hFFFF) undrn++;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    bus.prefena   = d_ena;
    bus.prefflush = d_flush;
    bus.prefreq   = d_req;
    for (int c = 0; c < NCH; c++) begin
      gd[c] = 16'($urandom);
      bus.gendat[c*DW +: DW] = gd[c];
    end
    #1;
    model_expect();
    s_genreq = bus.genreq;
    s_vld    = bus.prefvld;
    s_dout   = bus.prefdout;
    chk("genreq", 32'(s_genreq), 32'(eg));
    chk("prefvld", 32'(s_vld), 32'(ev));
    chk("prefdout", 32'(s_dout), 32'(edout));
`ifdef MST_PREF_STAT_EN
    chk("pref_undrn", 32'(pref_undrn), 32'(undrn));
`endif
    model_advance();
    d_flush = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    d_ena = '0; d_flush = '0; d_req = 1'b0;
    bus.prefena = '0; bus.prefflush = '0; bus.prefreq = 1'b0;
    #1;
    chk("rst_prefvld", 32'(bus.prefvld), 32'd0);
    chk("rst_genreq", 32'(bus.genreq), 32'd0);
    chk("rst_prefdout", 32'(bus.prefdout), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int cnt;
    int found;
    rst = 1'b1;
    d_ena = '0; d_flush = '0; d_req = 1'b0;
    bus.prefena = '0; bus.prefflush = '0; bus.prefreq = 1'b0; bus.gendat = '0;
    model_reset();

    // Reset during traffic, then restart.
    do_reset();
    d_ena = 2'b01;
    repeat (6) step();
    chk("pre_rst_vld", 32'(s_vld), 32'd1);
    do_reset();
    d_ena = 2'b01;
    step();
    step();
    chk("rel_genreq0", 32'(s_genreq[0]), 32'd1);

    // Fill channel 0 without pops.
    do_reset();
    d_ena = 2'b01;
    cnt = 0;
    repeat (12) begin
      step();
      cnt += int'(s_genreq[0]);
    end
    chk("fill_pulses", 32'(cnt), 32'd4);
    chk("fill_genreq_hold", 32'(s_genreq[0]), 32'd0);
    chk("fill_vld", 32'(s_vld), 32'd1);
    chk("fill_chid", 32'(s_dout[dout_chid_lsb(DW)]), 32'd0);

    // Both channels full, drain alternately.
    do_reset();
    d_ena = 2'b11;
    repeat (12) step();
    d_ena = 2'b00;
    step();
    d_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_vld", 32'(s_vld), 32'd1);
      chk("rr_chid", 32'(s_dout[dout_chid_lsb(DW)]), 32'(i % 2));
    end
    step();
    chk("rr_empty", 32'(s_vld), 32'd0);
    d_req = 1'b0;

    // Only channel 0 holds data.
    do_reset();
    d_ena = 2'b01;
    repeat (12) step();
    d_ena = 2'b00;
    step();
    d_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("solo_chid", 32'(s_dout[dout_chid_lsb(DW)]), 32'd0);
    end
    d_req = 1'b0;

    // Disable channel 1 with three words left after the same-cycle pop.
    do_reset();
    d_ena = 2'b10;
    repeat (12) step();
    d_ena = 2'b00;
    d_req = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dis_chid", 32'(s_dout[dout_chid_lsb(DW)]), 32'd1);
      chk("dis_genreq1", 32'(s_genreq[1]), 32'd0);
    end
    step();
    chk("dis_empty", 32'(s_vld), 32'd0);
    d_req = 1'b0;

    // Flush with two buffered words and one in flight.
    do_reset();
    d_ena = 2'b01;
    repeat (4) step();
    d_flush = 2'b01;
    step();
    chk("preflush_vld", 32'(s_vld), 32'd1);
    step();
    chk("flush_vld", 32'(s_vld), 32'd0);
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      step();
      if (s_genreq[0]) found = 1;
    end
    chk("flush_resume", 32'(found), 32'd1);

`ifdef MST_PREF_STAT_EN
    do_reset();
    d_req = 1'b1;
    repeat (5) step();
    d_req = 1'b0;
    step();
    chk("undrn_five", 32'(pref_undrn), 32'd5);
`endif

    // Random traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) d_ena[$urandom_range(0, 1)] ^= 1'b1;
      d_flush[0] = ($urandom_range(0, 29) == 0);
      d_flush[1] = ($urandom_range(0, 29) == 0);
      d_req      = ($urandom_range(0, 2) != 0);
      step();
      if (i == 2000) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
